// File: rtl/dmem_bus.sv
// CPU data-port responder: byte-lane RAM plus MMIO page (TX FIFO, status, cycle counter).
// Reads are combinational, writes land at the next edge; a full TX FIFO drops pushes and sets overflow.
module dmem_bus #(
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(MEM_WORDS * 4);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle;

  logic          ram_sel, mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          empty, full, pop, push, txdata_wr, ovf_set, ovf_clr, cycle_ld;

  assign ram_sel  = daddr < RAM_LIMIT;
  assign ram_idx  = daddr[AW+1:2];
  assign mmio_sel = daddr[31:4] == 28'h8000000;
  assign reg_sel  = daddr[3:2];

  assign empty    = count == '0;
  assign full     = count == FIFO_FULL;
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign txdata_wr = mmio_sel && reg_sel == 2'd0 && we[0];
  assign push      = txdata_wr && (!full || pop);
  assign ovf_set   = txdata_wr && full && !pop;
  assign ovf_clr   = mmio_sel && reg_sel == 2'd1 && we[0] && dwdata[2];
  assign cycle_ld  = mmio_sel && reg_sel == 2'd2 && we == 4'b1111;

  always_comb begin
    drdata = 32'h0;
    if (ram_sel) begin
      drdata = mem[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        2'd1:    drdata = {16'h0, 8'(count), 5'h0, overflow, full, empty};
        2'd2:    drdata = cycle;
        default: drdata = 32'h0;
      endcase
    end
  end

  // RAM has no reset; contents survive reset_n but writes are blocked while it is low.
  always_ff @(posedge clk) begin
    if (reset_n && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) fifo_mem[wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycle    <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      cycle <= cycle_ld ? dwdata : cycle + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: vector table for RAM/FIFO/status plus hand sequences for counter and reset.
module tb_dmem_bus;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  we;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] TXD = 32'h8000_0000;
  localparam logic [31:0] STA = 32'h8000_0004;
  localparam logic [31:0] CYC = 32'h8000_0008;
  localparam logic [31:0] RSV = 32'h8000_000C;
  localparam logic [31:0] UNM = 32'h4000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_vld;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs[$];

  dmem_bus #(.MEM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .we       (we),
    .drdata   (drdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                     input logic r, input logic c, input logic [31:0] er,
                     input logic ev, input logic [7:0] et);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = w; v.rdy = r;
    v.chk_rd = c; v.exp_rd = er; v.exp_vld = ev; v.exp_tx = et;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       input logic r);
    daddr = a; dwdata = d; we = w; tx_ready = r;
  endtask

  initial begin
    logic [7:0] seq [8];
    int c;

    // RAM byte lanes; checked reads during a write see the pre-edge word
    add(32'h10, 32'hAABBCCDD, 4'hF, 0, 0, 32'h0, 0, 8'h00);
    add(32'h10, 32'h00000011, 4'h1, 0, 1, 32'hAABBCCDD, 0, 8'h00);
    add(32'h10, 32'h0, 4'h0, 0, 1, 32'hAABBCC11, 0, 8'h00);
    add(32'h10, 32'h55660000, 4'hC, 0, 1, 32'hAABBCC11, 0, 8'h00);
    add(32'h10, 32'h0, 4'h0, 0, 1, 32'h5566CC11, 0, 8'h00);
    add(UNM, 32'h12345678, 4'hF, 0, 1, 32'h0, 0, 8'h00);
    add(RSV, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0, 0, 8'h00);
    add(TXD, 32'h77, 4'hE, 0, 1, 32'h0, 0, 8'h00);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h1, 0, 8'h00);
    // FIFO drain
    add(TXD, 32'h41, 4'h1, 0, 1, 32'h0, 0, 8'h00);
    add(TXD, 32'h42, 4'h1, 0, 1, 32'h0, 1, 8'h41);
    add(TXD, 32'h43, 4'h1, 0, 1, 32'h0, 1, 8'h41);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h300, 1, 8'h41);
    add(STA, 32'h0, 4'h0, 1, 1, 32'h300, 1, 8'h41);
    add(STA, 32'h0, 4'h0, 1, 1, 32'h200, 1, 8'h42);
    add(STA, 32'h0, 4'h0, 1, 1, 32'h100, 1, 8'h43);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h1, 0, 8'h00);
    // Nine pushes into an 8-deep FIFO
    for (int i = 0; i < 9; i++)
      add(TXD, 32'h50 + 32'(i), 4'h1, 0, 1, 32'h0, i > 0, (i > 0) ? 8'h50 : 8'h00);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h806, 1, 8'h50);
    add(STA, 32'h4, 4'h1, 0, 1, 32'h806, 1, 8'h50);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h802, 1, 8'h50);
    // Push while full with a simultaneous pop
    add(TXD, 32'h60, 4'h1, 1, 1, 32'h0, 1, 8'h50);
    add(STA, 32'h0, 4'h0, 0, 1, 32'h802, 1, 8'h51);
    for (int i = 0; i < 8; i++) seq[i] = (i < 7) ? 8'h51 + 8'(i) : 8'h60;
    for (int i = 0; i < 8; i++) begin
      c = 8 - i;
      add(STA, 32'h0, 4'h0, 1, 1, 32'(c << 8) | ((c == 8) ? 32'h2 : 32'h0), 1, seq[i]);
    end
    add(STA, 32'h0, 4'h0, 0, 1, 32'h1, 0, 8'h00);

    // Reset state
    reset_n = 1'b0;
    drive(STA, 32'h0, 4'h0, 0);
    #12;
    check("rst_status", drdata, 32'h1);
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    daddr = CYC;
    #1;
    check("rst_cycle", drdata, 32'h0);

    // Cycle counter from reset release, then load/wrap and partial-write ignore
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("cycle_0", drdata, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("cycle_5", drdata, 32'h5);
    drive(CYC, 32'hFFFFFFFE, 4'hF, 0);
    @(posedge clk); #1;
    drive(CYC, 32'h0, 4'b0111, 0);
    #1;
    check("cycle_load", drdata, 32'hFFFFFFFE);
    @(posedge clk); #1;
    we = 4'h0;
    #1;
    check("cycle_ffff", drdata, 32'hFFFFFFFF);
    @(posedge clk); #2;
    check("cycle_wrap", drdata, 32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d drdata", i), drdata, vecs[i].exp_rd);
      check($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_tx));
      @(posedge clk); #1;
    end

    // Async reset mid-drain with 4 bytes queued
    for (int i = 0; i < 4; i++) begin
      drive(TXD, 32'hA0 + 32'(i), 4'h1, 0);
      @(posedge clk); #1;
    end
    drive(STA, 32'h0, 4'h0, 0);
    #1;
    check("pre_rst_status", drdata, 32'h400);
    check("pre_rst_txdata", 32'(tx_data), 32'hA0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'h0);
    check("arst_txdata", 32'(tx_data), 32'h0);
    drive(32'h10, 32'h0, 4'hF, 1);
    @(posedge clk); #1;
    drive(STA, 32'h0, 4'h0, 0);
    #1;
    check("in_rst_status", drdata, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_status", drdata, 32'h1);
    check("post_rst_valid", 32'(tx_valid), 32'h0);
    daddr = 32'h10;
    #1;
    check("ram_kept", drdata, 32'h5566CC11);
    daddr = UNM;
    #1;
    check("unmapped", drdata, 32'h0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Data-side responder for the single-cycle CPU. It answers the CPU's `daddr`/`dwdata`/`we`/`drdata` port with a byte-lane-writable RAM and a small memory-mapped peripheral page. The page holds a transmit FIFO that drains to an external byte sink over a valid/ready handshake, a status register and a free-running cycle counter. It sits between the CPU's data port and the board-level console/debug sink.

## Interface
Parameters:
- `MEM_WORDS`, 256: RAM depth in 32-bit words; a power of two.
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes; a power of two, at most 128.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `daddr`  in  32  byte address from the CPU.
- `dwdata`  in  32  write data from the CPU, already lane-shifted.
- `we`  in  4  per-byte write enables; `we[i]` writes `dwdata[8i+7:8i]`.
- `drdata`  out  32  read data; combinational from `daddr` in the same cycle.
- `tx_data`  out  8  byte at the FIFO head.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts the head byte this cycle.

## Operation
Address decode uses the full `daddr`:
- **RAM**: `daddr < MEM_WORDS*4`. Word index is `daddr[log2(MEM_WORDS)+1:2]`.
- **MMIO**: `daddr[31:4] == 28'h8000000`. Register select is `daddr[3:2]`.
- **Anything else**: unmapped. Reads return 0 and writes are ignored.

RAM:
- Each lane with `we[i]=1` is written at the edge.
- `drdata` returns the whole stored word, with no lane shifting.

MMIO registers:
- **0x8000_0000 TXDATA**
  - A write with `we[0]=1` pushes `dwdata[7:0]`.
  - Reads return 0.
- **0x8000_0004 STATUS**
  - Read layout: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count, all other bits 0.
  - A write with `we[0]=1` and `dwdata[2]=1` clears overflow.
- **0x8000_0008 CYCLE**
  - Reads return the current counter value.
  - A write with `we==4'b1111` loads `dwdata`.
  - Partial writes are ignored.
- **0x8000_000C**: reserved. Reads return 0 and writes are ignored.

FIFO:
- Circular buffer with read pointer, write pointer and a count register of width log2(FIFO_DEPTH)+1; `count` ranges 0..FIFO_DEPTH.
- `tx_valid = (count != 0)`.
- `tx_data` is the head byte when non-empty, else 8'h00.
- **pop**: `tx_valid && tx_ready`.
- **push**: a TXDATA write that is accepted, which requires `count < FIFO_DEPTH` or a pop in the same cycle.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance.
- Push when full with no pop: the byte is dropped, overflow is set (sticky), and the pointers are unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- If a set and a clear of overflow occur in the same cycle, set wins.

Cycle counter:
- 32-bit; increments by 1 every edge and wraps from 0xFFFF_FFFF to 0.
- A load has priority over the increment: after a load edge the value is `dwdata`, and it counts up from there on the following edges.

## Timing
- Reads are combinational, with zero latency. MMIO reads have no side effects, so the CPU may present an address for a full cycle safely.
- Writes and pushes take effect at the rising edge that ends the cycle in which they are presented.
- Status visible in the same cycle as a push reflects the pre-edge state.
- A byte pushed at edge N raises `tx_valid` after edge N, so the earliest pop is at edge N+1.
- `tx_data`/`tx_valid` hold stable until a pop.
- Reset (`reset_n` low, asynchronous, at any time including mid-drain):
  - `count`=0, both pointers=0, overflow=0, cycle counter=0.
  - `tx_valid`=0 and `tx_data`=8'h00 immediately.
  - RAM contents are not cleared.
  - Bytes queued in the FIFO are lost.
  - Writes are ignored while `reset_n` is low.

## Test plan
- **RAM byte lanes**: write 0xAABBCCDD with `we`=4'b1111 to 0x10, then 0x00000011 with `we`=4'b0001 to 0x10 → reading 0x10 returns 0xAABBCC11. Then `we`=4'b1100 with `dwdata` 0x55660000 → returns 0x5566CC11.
- **FIFO drain**: hold `tx_ready`=0 and push 0x41,0x42,0x43 → STATUS=0x00000300. Raise `tx_ready` → `tx_data` sequence 0x41,0x42,0x43 on consecutive cycles, then `tx_valid`=0 and STATUS=0x00000001.
- **Full/overflow**: with `tx_ready`=0, push 9 bytes (FIFO_DEPTH=8) → STATUS=0x00000806 and the 9th byte never appears. Write STATUS with `dwdata`=0x4 → overflow clears.
- **Simultaneous push+pop at full**: FIFO full with `tx_ready`=1 during a push → the push is accepted, count stays 8, overflow stays 0.
- **Cycle counter**: after reset, read CYCLE at the 5th cycle → 5. Load 0xFFFFFFFE → reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the following cycles.
- **Async reset mid-drain**: pull `reset_n` low between edges with 4 bytes queued → `tx_valid` drops without waiting for a clock. After release, STATUS=0x00000001 and RAM data is preserved. Unmapped 0x4000_0000 reads 0.
